neuron_sigmoid_pipe: RTL and testbench

Parametrised, multi-lane sigmoid output neuron with a start/done handshake. It computes the weighted sum, a hard-sigmoid activation and, in train mode, the output delta and updated weights and bias in a single transaction. `LANES` multipliers work in parallel. All inputs are latched at start, so the caller may change them while the block is busy. The block sits in the output layer: it feeds `dz_out` to the hidden-layer backprop and `w_out` to the weight store.

---
 rtl/neuron_sigmoid_pipe.sv | 195 +++++++++++++++++++
 tb/tb_neuron_sigmoid_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_sigmoid_pipe.sv
// neuron_sigmoid_pipe
// Output-layer sigmoid neuron. It runs the weighted sum, a hard-sigmoid
// activation and, in train mode, the output delta and weight/bias update as
// one start/done transaction. LANES multiply-accumulate lanes run in parallel.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start, mode     begin transaction (IDLE only); 0 = forward, 1 = train
//   x, w, b         inputs, weights, bias (latched at start)
//   y_true, lr      target label, negative learning rate (latched at start)
//   busy, done      transaction in progress, one-cycle completion pulse
//   y, yhat         hard-sigmoid output, predicted class
//   dz_out          y - y_true
//   w_out           updated {w, b}; index N holds the bias
//
// state  | meaning
// IDLE   | waiting for start; inputs latched on start
// MAC    | C cycles, LANES products accumulated per cycle
// ACT    | z = sat(acc + b), y and yhat registered
// DZ     | dz_out = sat(y - y_true)
// UPD    | U cycles, LANES entries of w_out written per cycle
module neuron_sigmoid_pipe #(
   parameter int N     = 30,
   parameter int BITS  = 16,
   parameter int FRAC  = 8,
   parameter int LANES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   mode,
   input  logic [N-1:0][BITS-1:0] x,
   input  logic [N-1:0][BITS-1:0] w,
   input  logic [BITS-1:0]        b,
   input  logic [BITS-1:0]        y_true,
   input  logic [BITS-1:0]        lr,
   output logic                   busy,
   output logic                   done,
   output logic [BITS-1:0]        y,
   output logic                   yhat,
   output logic [BITS-1:0]        dz_out,
   output logic [N:0][BITS-1:0]   w_out
);

   localparam int C     = (N + LANES - 1) / LANES;
   localparam int U     = (N + LANES) / LANES;
   localparam int ACC_W = BITS + $clog2(N + 1);
   localparam int SW    = 2 * BITS + $clog2(N + 1) + 2;
   localparam int IW    = $clog2(N + LANES + 1);
   localparam int CW    = $clog2(U + 1);

   localparam logic signed [SW-1:0] S_MAX = {{(SW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
   localparam logic signed [SW-1:0] S_MIN = {{(SW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
   localparam logic signed [BITS+1:0] Y_HALF = (BITS+2)'(1 << (FRAC - 1));
   localparam logic signed [BITS+1:0] Y_ONE  = (BITS+2)'(1 << FRAC);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MAC  = 3'd1;
   localparam logic [2:0] S_ACT  = 3'd2;
   localparam logic [2:0] S_DZ   = 3'd3;
   localparam logic [2:0] S_UPD  = 3'd4;

   function automatic logic signed [BITS-1:0] sat(input logic signed [SW-1:0] v);
      if (v > S_MAX) return {1'b0, {(BITS-1){1'b1}}};
      if (v < S_MIN) return {1'b1, {(BITS-1){1'b0}}};
      return v[BITS-1:0];
   endfunction

   // Full-width product, floor shift back to Q format, then saturate.
   function automatic logic signed [BITS-1:0] fx_mul(input logic signed [BITS-1:0] a,
                                                      input logic signed [BITS-1:0] c);
      logic signed [2*BITS-1:0] p;
      p = (2*BITS)'(a) * (2*BITS)'(c);
      return sat(SW'(p >>> FRAC));
   endfunction

   logic [2:0]                state;
   logic [CW-1:0]             cnt;
   logic [IW-1:0]             idx;
   logic signed [ACC_W-1:0]   acc;
   logic [N-1:0][BITS-1:0]    x_r;
   logic [N-1:0][BITS-1:0]    w_r;
   logic signed [BITS-1:0]    b_r;
   logic signed [BITS-1:0]    yt_r;
   logic signed [BITS-1:0]    lr_r;
   logic                      mode_r;

   logic signed [ACC_W-1:0]   mac_sum;
   logic [N:0][BITS-1:0]      w_next;
   logic [IW-1:0]             k;
   logic signed [BITS-1:0]    z;
   logic signed [BITS+1:0]    y_ext;
   logic [BITS-1:0]           y_act;
   logic [BITS-1:0]           dz_calc;

   assign busy = (state != S_IDLE);

   // Lane k = idx + l; lanes past N add nothing, lane N carries the bias.
   always_comb begin
      mac_sum = '0;
      w_next  = w_out;
      k       = '0;
      for (int l = 0; l < LANES; l++) begin
         k = idx + IW'(l);
         if (k < IW'(N)) begin
            mac_sum = mac_sum + ACC_W'(fx_mul(x_r[k], w_r[k]));
            w_next[k] = sat(SW'($signed(w_r[k])) +
                            SW'(fx_mul(lr_r, fx_mul(dz_out, x_r[k]))));
         end else if (k == IW'(N)) begin
            w_next[N] = sat(SW'(b_r) + SW'(fx_mul(lr_r, dz_out)));
         end
      end
   end

   always_comb begin
      z     = sat(SW'(acc) + SW'(b_r));
      y_ext = (BITS+2)'(z >>> 2) + Y_HALF;
      if (y_ext[BITS+1])      y_act = '0;
      else if (y_ext > Y_ONE) y_act = Y_ONE[BITS-1:0];
      else                    y_act = y_ext[BITS-1:0];
      dz_calc = sat(SW'($signed(y)) - SW'(yt_r));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         idx    <= '0;
         acc    <= '0;
         x_r    <= '0;
         w_r    <= '0;
         b_r    <= '0;
         yt_r   <= '0;
         lr_r   <= '0;
         mode_r <= 1'b0;
         done   <= 1'b0;
         y      <= '0;
         yhat   <= 1'b0;
         dz_out <= '0;
         w_out  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_r    <= x;
                  w_r    <= w;
                  b_r    <= b;
                  yt_r   <= y_true;
                  lr_r   <= lr;
                  mode_r <= mode;
                  acc    <= '0;
                  idx    <= '0;
                  cnt    <= CW'(C - 1);
                  state  <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + mac_sum;
               idx <= idx + IW'(LANES);
               if (cnt == '0) state <= S_ACT;
               else           cnt   <= cnt - 1'b1;
            end
            S_ACT: begin
               y    <= y_act;
               yhat <= ~z[BITS-1];
               if (mode_r) begin
                  state <= S_DZ;
               end else begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            S_DZ: begin
               dz_out <= dz_calc;
               idx    <= '0;
               cnt    <= CW'(U - 1);
               state  <= S_UPD;
            end
            S_UPD: begin
               w_out <= w_next;
               idx   <= idx + IW'(LANES);
               if (cnt == '0) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_sigmoid_pipe.sv
module tb_neuron_sigmoid_pipe;
   localparam int N = 30, BITS = 16, FRAC = 8, LANES = 2, NP = 5;

   logic clk = 1'b0;
   logic rst, start, mode, start_p, mode_p;
   logic [N-1:0][BITS-1:0]  x, w;
   logic [BITS-1:0]         b, y_true, lr;
   logic                    busy, done, yhat;
   logic [BITS-1:0]         y, dz_out;
   logic [N:0][BITS-1:0]    w_out, wexp;
   logic [NP-1:0][BITS-1:0] x_p, w_p;
   logic [BITS-1:0]         b_p, yt_p, lr_p;
   logic                    busy_p, done_p, yhat_p;
   logic [BITS-1:0]         y_p, dz_out_p;
   logic [NP:0][BITS-1:0]   w_out_p, wexp_p;

   int n_cmp = 0, n_fail = 0;
   int ed, nd, first;
   int dn [3];
   logic [BITS-1:0] dz17;
   logic busy0;

   always #5 clk = ~clk;

   neuron_sigmoid_pipe #(.N(N), .BITS(BITS), .FRAC(FRAC), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .w(w), .b(b),
      .y_true(y_true), .lr(lr), .busy(busy), .done(done), .y(y), .yhat(yhat),
      .dz_out(dz_out), .w_out(w_out));

   neuron_sigmoid_pipe #(.N(NP), .BITS(BITS), .FRAC(FRAC), .LANES(LANES)) dut_p (
      .clk(clk), .rst(rst), .start(start_p), .mode(mode_p), .x(x_p), .w(w_p), .b(b_p),
      .y_true(yt_p), .lr(lr_p), .busy(busy_p), .done(done_p), .y(y_p), .yhat(yhat_p),
      .dz_out(dz_out_p), .w_out(w_out_p));

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts one transaction; edges = edge number (edge 0 samples start) after which done is high.
   task automatic run(input bit pad, input bit md, output int edges);
      @(negedge clk);
      if (pad) begin start_p = 1'b1; mode_p = md; end
      else     begin start   = 1'b1; mode   = md; end
      @(posedge clk); #1;
      busy0   = pad ? busy_p : busy;
      start   = 1'b0;
      start_p = 1'b0;
      edges   = 999;
      for (int e = 1; e <= 200; e++) begin
         @(posedge clk); #1;
         if (e == 17) dz17 = dz_out;
         if (pad ? done_p : done) begin
            edges = e;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; start_p = 1'b0; mode_p = 1'b0;
      x = '0; w = '0; b = '0; y_true = '0; lr = '0;
      x_p = '0; w_p = '0; b_p = '0; yt_p = '0; lr_p = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_y", y, 0);
      check("rst_wout", w_out, 0);
      @(negedge clk) rst = 1'b0;

      // forward, z = 30 * 8/256 = 0x00F0
      for (int i = 0; i < N; i++) begin x[i] = 16'h0100; w[i] = 16'h0008; end
      run(0, 0, ed);
      check("fwd_busy_after_e0", busy0, 1);
      check("fwd_done_edge", ed, 16);
      check("fwd_y", y, 16'h00BC);
      check("fwd_yhat", yhat, 1);
      check("fwd_dz_hold", dz_out, 16'h0000);
      check("fwd_busy_drop", busy, 0);
      @(posedge clk); #1;
      check("fwd_done_one_cycle", done, 0);

      for (int i = 0; i < N; i++) begin x[i] = 16'h7FFF; w[i] = 16'h7FFF; end
      run(0, 0, ed);
      check("satp_y", y, 16'h0100);
      check("satp_yhat", yhat, 1);
      for (int i = 0; i < N; i++) w[i] = 16'h8000;
      run(0, 0, ed);
      check("satn_y", y, 16'h0000);
      check("satn_yhat", yhat, 0);

      // train: y = 0.5, dz = -0.5, each update = -0.5 * (-0.5 * 1.0) = +0.25
      for (int i = 0; i < N; i++) begin x[i] = 16'h0100; w[i] = 16'h0000; end
      b = '0; y_true = 16'h0100; lr = 16'hFF80;
      run(0, 1, ed);
      for (int i = 0; i <= N; i++) wexp[i] = 16'h0040;
      check("trn_done_edge", ed, 33);
      check("trn_dz_at_e17", dz17, 16'hFF80);
      check("trn_y", y, 16'h0080);
      check("trn_dz", dz_out, 16'hFF80);
      check("trn_wout", w_out, wexp);

      // forward run leaves dz_out and w_out alone
      for (int i = 0; i < N; i++) w[i] = 16'h0008;
      run(0, 0, ed);
      check("hold_y", y, 16'h00BC);
      check("hold_dz", dz_out, 16'hFF80);
      check("hold_wout", w_out, wexp);

      // reset in the middle of UPD
      for (int i = 0; i < N; i++) w[i] = 16'h0000;
      @(negedge clk); start = 1'b1; mode = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (20) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rstupd_busy", busy, 0);
      check("rstupd_done", done, 0);
      check("rstupd_wout", w_out, 0);
      check("rstupd_y", y, 0);
      check("rstupd_dz", dz_out, 0);

      // start held during reset is only taken after release
      start = 1'b1; mode = 1'b0;
      @(posedge clk); #1;
      check("rst_start_busy", busy, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("rel_start_busy", busy, 1);
      ed = 999;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (done) begin ed = e; break; end
      end
      check("rel_done_edge", ed, 16);

      // train after reset: z saturates y to 1.0, dz = 1.0, w += -0.5
      for (int i = 0; i < N; i++) w[i] = 16'h0100;
      y_true = 16'h0000;
      run(0, 1, ed);
      for (int i = 0; i < N; i++) wexp[i] = 16'h0080;
      wexp[N] = 16'hFF80;
      check("trn2_done_edge", ed, 33);
      check("trn2_y", y, 16'h0100);
      check("trn2_dz", dz_out, 16'h0100);
      check("trn2_wout", w_out, wexp);

      // lane padding, N = 5: C = 3, U = 3
      for (int i = 0; i < NP; i++) begin x_p[i] = 16'h0100; w_p[i] = 16'h0100; end
      b_p = '0; yt_p = '0; lr_p = 16'hFF80;
      run(1, 0, ed);
      check("pad_fwd_edge", ed, 4);
      check("pad_y", y_p, 16'h0100);
      check("pad_yhat", yhat_p, 1);
      run(1, 1, ed);
      for (int i = 0; i < NP; i++) wexp_p[i] = 16'h0080;
      wexp_p[NP] = 16'hFF80;
      check("pad_trn_edge", ed, 8);
      check("pad_dz", dz_out_p, 16'h0100);
      check("pad_wout", w_out_p, wexp_p);

      // start pulsed during MAC is ignored
      for (int i = 0; i < N; i++) w[i] = 16'h0008;
      @(negedge clk); start = 1'b1; mode = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      nd = 0; first = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (done) begin nd++; if (first < 0) first = e; end
         if (e == 5) start = 1'b1;
         if (e == 6) start = 1'b0;
      end
      check("mac_start_ndone", nd, 1);
      check("mac_start_edge", first, 16);

      // start held high: back-to-back forward runs
      dn[0] = -1; dn[1] = -1; dn[2] = -1; nd = 0;
      @(negedge clk); start = 1'b1; mode = 1'b0;
      for (int e = 0; e <= 55; e++) begin
         @(posedge clk); #1;
         if (done && nd < 3) begin dn[nd] = e; nd++; end
      end
      start = 1'b0;
      check("b2b_done0", dn[0], 16);
      check("b2b_done1", dn[1], 33);
      check("b2b_done2", dn[2], 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
